// File: rtl/lfsr_pkg.sv
// Shared constants, state encoding and feedback function for the 32-bit
// Fibonacci LFSR pattern (taps 32, 22, 2, 1).
package lfsr_pkg;

    localparam int LFSR_W = 32;
    localparam int TAP_A  = 32;
    localparam int TAP_B  = 22;
    localparam int TAP_C  = 2;
    localparam int TAP_D  = 1;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_VERIFY  = 2'd1,
        ST_CHECK   = 2'd2,
        ST_UNUSED  = 2'd3
    } state_t;

    // Stage 1 is the newest bit; the return value is the bit entering stage 1.
    function automatic logic lfsr_pred(input logic [1:LFSR_W] v);
        return v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D];
    endfunction

endpackage

// File: rtl/lfsr_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear plus increment in the
// same cycle loads 1.
module lfsr_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising receive checker for the LFSR pattern stream: acquires,
// verifies, then flywheels on its own prediction and counts bit errors.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 8,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state_o
);

    // Input handshake: din is consumed on every cycle din_valid is high and
    // ignored otherwise; there is no backpressure, one bit per clock.

    localparam logic [5:0] FILL_LAST = 6'(LFSR_W - 1);
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [7:0] LOSS_LAST = 8'(LOSS_CNT - 1);

    state_t            state;
    logic [1:LFSR_W]   hist;
    logic [5:0]        fill;
    logic [7:0]        good;
    logic [7:0]        bad;

    logic              pred;
    logic              miss;
    logic              err_hit;
    logic [1:LFSR_W]   hist_din;
    logic [1:LFSR_W]   hist_pred;

    assign pred      = lfsr_pred(hist);
    assign miss      = din ^ pred;
    assign hist_din  = {din,  hist[1:LFSR_W-1]};
    assign hist_pred = {pred, hist[1:LFSR_W-1]};
    assign err_hit   = din_valid && (state == ST_CHECK) && miss;
    assign state_o   = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_ACQUIRE;
            hist      <= '0;
            fill      <= '0;
            good      <= '0;
            bad       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= err_hit;
            case (state)
                ST_ACQUIRE: begin
                    if (din_valid) begin
                        hist <= hist_din;
                        if (fill == FILL_LAST) begin
                            // An all-zero window is the LFSR lock-up pattern.
                            if (hist_din == '0) begin
                                fill <= '0;
                            end else begin
                                fill  <= fill + 6'd1;
                                good  <= '0;
                                state <= ST_VERIFY;
                            end
                        end else begin
                            fill <= fill + 6'd1;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (din_valid) begin
                        hist <= hist_din;
                        if (miss) begin
                            good <= '0;
                        end else if (good == LOCK_LAST) begin
                            bad    <= '0;
                            state  <= ST_CHECK;
                            locked <= 1'b1;
                        end else begin
                            good <= good + 8'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (din_valid) begin
                        // Flywheel: shift the prediction so line errors do not propagate.
                        hist <= hist_pred;
                        if (!miss) begin
                            bad <= '0;
                        end else if (bad == LOSS_LAST) begin
                            state  <= ST_ACQUIRE;
                            locked <= 1'b0;
                            fill   <= '0;
                            good   <= '0;
                            bad    <= '0;
                        end else begin
                            bad <= bad + 8'd1;
                        end
                    end
                end
                default: begin
                    state  <= ST_ACQUIRE;
                    locked <= 1'b0;
                    fill   <= '0;
                    good   <= '0;
                    bad    <= '0;
                end
            endcase
        end
    end

    lfsr_sat_cnt #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (err_clr),
        .inc (err_hit),
        .cnt (err_cnt)
    );

endmodule
